// File: rtl/adc_seq_responder.sv
// Device-side model of the ADC sequencer: CSR decode, fixed channel sequence,
// and a one-beat-per-slot response stream fed from an external sample port.
module adc_seq_responder #(
  parameter int unsigned            NUM_SLOTS    = 2,
  parameter logic [5*NUM_SLOTS-1:0] CH_LIST      = {5'd1, 5'd17},
  parameter int unsigned            CONV_CYCLES  = 4,
  parameter int unsigned            RECAL_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sequencer_csr_address,
  input  logic        sequencer_csr_read,
  input  logic        sequencer_csr_write,
  input  logic [31:0] sequencer_csr_writedata,
  output logic [31:0] sequencer_csr_readdata,
  output logic [4:0]  sample_ch,
  input  logic [11:0] sample_data,
  output logic        response_valid,
  output logic [4:0]  response_channel,
  output logic [11:0] response_data,
  output logic        response_startofpacket,
  output logic        response_endofpacket
);

  localparam int unsigned SW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned MAXC = (CONV_CYCLES > RECAL_CYCLES) ? CONV_CYCLES : RECAL_CYCLES;
  localparam int unsigned CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  typedef enum logic [1:0] {IDLE, CONV, EMIT, RECAL} state_t;
  typedef enum logic [2:0] {
    MODE_CONT   = 3'b000,
    MODE_SINGLE = 3'b001,
    MODE_RECAL  = 3'b111
  } mode_t;

  state_t          state;
  logic            ctrl_run;
  logic [2:0]      ctrl_mode;
  logic [SW-1:0]   slot;
  logic [CW-1:0]   cnt;
  logic [11:0]     data_cap;

  logic            ctrl_wr;
  logic [2:0]      wr_mode;
  logic            mode_ok;
  logic            last_slot;
  logic            unused_wd;

  assign ctrl_wr   = sequencer_csr_write && !sequencer_csr_address;
  assign wr_mode   = sequencer_csr_writedata[3:1];
  assign mode_ok   = (wr_mode == MODE_CONT) || (wr_mode == MODE_SINGLE) || (wr_mode == MODE_RECAL);
  assign last_slot = (slot == SW'(NUM_SLOTS - 1));
  assign unused_wd = ^sequencer_csr_writedata[31:4];

  function automatic logic [4:0] ch_of(input logic [SW-1:0] s);
    logic [4:0] ch;
    ch = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (s == SW'(i)) ch = CH_LIST[5*i +: 5];
    end
    return ch;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= IDLE;
      ctrl_run               <= 1'b0;
      ctrl_mode              <= '0;
      slot                   <= '0;
      cnt                    <= '0;
      data_cap               <= '0;
      sample_ch              <= '0;
      sequencer_csr_readdata <= '0;
      response_valid         <= 1'b0;
      response_channel       <= '0;
      response_data          <= '0;
      response_startofpacket <= 1'b0;
      response_endofpacket   <= 1'b0;
    end else begin
      response_valid <= 1'b0;

      // Nonblocking update means a read coinciding with a write sees the old value.
      if (sequencer_csr_read) begin
        if (sequencer_csr_address)
          sequencer_csr_readdata <= {31'b0, (state != IDLE)};
        else
          sequencer_csr_readdata <= {28'b0, ctrl_mode, ctrl_run};
      end

      // While busy only continuous mode honours RUN; later case branches may override.
      if (ctrl_wr && (state != IDLE) && (ctrl_mode == MODE_CONT))
        ctrl_run <= sequencer_csr_writedata[0];

      case (state)
        IDLE: begin
          if (ctrl_wr) begin
            ctrl_mode <= wr_mode;
            ctrl_run  <= sequencer_csr_writedata[0] & mode_ok;
            if (sequencer_csr_writedata[0] && mode_ok) begin
              slot <= '0;
              cnt  <= '0;
              if (wr_mode == MODE_RECAL) begin
                state <= RECAL;
              end else begin
                state     <= CONV;
                sample_ch <= ch_of('0);
              end
            end
          end
        end
        CONV: begin
          if (cnt == CW'(CONV_CYCLES - 1)) begin
            cnt      <= '0;
            data_cap <= sample_data;
            state    <= EMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EMIT: begin
          response_valid         <= 1'b1;
          response_channel       <= sample_ch;
          response_data          <= data_cap;
          response_startofpacket <= (slot == '0);
          response_endofpacket   <= last_slot;
          if (!last_slot) begin
            slot      <= slot + 1'b1;
            sample_ch <= ch_of(slot + 1'b1);
            state     <= CONV;
          end else if ((ctrl_mode == MODE_CONT) && ctrl_run) begin
            slot      <= '0;
            sample_ch <= ch_of('0);
            state     <= CONV;
          end else begin
            ctrl_run <= 1'b0;
            state    <= IDLE;
          end
        end
        RECAL: begin
          if (cnt == CW'(RECAL_CYCLES - 1)) begin
            cnt      <= '0;
            ctrl_run <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_seq_responder.sv
// Directed bench for adc_seq_responder: single, repeated-write, continuous stop,
// recalibration, reserved mode, simultaneous read/write and mid-sequence reset.
module tb_adc_seq_responder;

  logic        clk;
  logic        rst;
  logic        csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic [4:0]  sample_ch;
  logic [11:0] sample_data;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        response_sop;
  logic        response_eop;

  int n_cmp;
  int n_err;

  adc_seq_responder #(
    .NUM_SLOTS   (2),
    .CH_LIST     ({5'd1, 5'd17}),
    .CONV_CYCLES (4),
    .RECAL_CYCLES(16)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .sequencer_csr_address  (csr_address),
    .sequencer_csr_read     (csr_read),
    .sequencer_csr_write    (csr_write),
    .sequencer_csr_writedata(csr_writedata),
    .sequencer_csr_readdata (csr_readdata),
    .sample_ch              (sample_ch),
    .sample_data            (sample_data),
    .response_valid         (response_valid),
    .response_channel       (response_channel),
    .response_data          (response_data),
    .response_startofpacket (response_sop),
    .response_endofpacket   (response_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known sample source: ch17 -> 0xA5A, ch1 -> 0x123.
  assign sample_data = (sample_ch == 5'd17) ? 12'hA5A :
                       (sample_ch == 5'd1)  ? 12'h123 : 12'h000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [31:0] d);
    csr_address   = 1'b0;
    csr_writedata = d;
    csr_write     = 1'b1;
    tick();
    csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic a);
    csr_address = a;
    csr_read    = 1'b1;
    tick();
    csr_read    = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_readdata"}, csr_readdata, 32'h0);
    check({tag, "_sample_ch"}, {27'b0, sample_ch}, 32'h0);
    check({tag, "_valid"}, {31'b0, response_valid}, 32'h0);
    check({tag, "_channel"}, {27'b0, response_channel}, 32'h0);
    check({tag, "_data"}, {20'b0, response_data}, 32'h0);
    check({tag, "_sop"}, {31'b0, response_sop}, 32'h0);
    check({tag, "_eop"}, {31'b0, response_eop}, 32'h0);
  endtask

  initial begin
    logic exp_v;
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b0;
    csr_address   = 1'b0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = '0;

    // Reset state
    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b1;
    tick();

    // Single sequence: beats at +5 and +10
    csr_wr(32'h3);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_v = (k == 5) || (k == 10);
      check("single_valid", {31'b0, response_valid}, {31'b0, exp_v});
      if (k == 1) check("single_sample_ch0", {27'b0, sample_ch}, 32'd17);
      if (k == 6) check("single_sample_ch1", {27'b0, sample_ch}, 32'd1);
      if (k == 5) begin
        check("b0_ch",  {27'b0, response_channel}, 32'd17);
        check("b0_dat", {20'b0, response_data}, 32'hA5A);
        check("b0_sop", {31'b0, response_sop}, 32'h1);
        check("b0_eop", {31'b0, response_eop}, 32'h0);
      end
      if (k == 10) begin
        check("b1_ch",  {27'b0, response_channel}, 32'd1);
        check("b1_dat", {20'b0, response_data}, 32'h123);
        check("b1_sop", {31'b0, response_sop}, 32'h0);
        check("b1_eop", {31'b0, response_eop}, 32'h1);
      end
      if (k == 12) begin
        check("hold_ch",  {27'b0, response_channel}, 32'd1);
        check("hold_dat", {20'b0, response_data}, 32'h123);
      end
    end
    csr_rd(1'b0);
    check("single_ctrl", csr_readdata, 32'h2);
    csr_rd(1'b1);
    check("single_busy", csr_readdata, 32'h0);

    // 0x3 every cycle for 40 edges: restart only from IDLE, one idle cycle per sequence
    csr_address   = 1'b0;
    csr_writedata = 32'h3;
    for (int k = 0; k < 50; k++) begin
      csr_write = (k < 40);
      tick();
      if (k >= 1) begin
        exp_v = (k <= 43) && (((k % 11) == 5) || ((k % 11) == 10));
        check("rep_valid", {31'b0, response_valid}, {31'b0, exp_v});
        if (exp_v) begin
          check("rep_sop", {31'b0, response_sop}, {31'b0, ((k % 11) == 5)});
          check("rep_eop", {31'b0, response_eop}, {31'b0, ((k % 11) == 10)});
        end
      end
    end
    csr_write = 1'b0;

    // Continuous, RUN cleared during slot 0 conversion
    csr_wr(32'h1);
    tick();
    tick();
    csr_wr(32'h0);
    for (int k = 4; k <= 20; k++) begin
      tick();
      exp_v = (k == 5) || (k == 10);
      check("cont_valid", {31'b0, response_valid}, {31'b0, exp_v});
      if (k == 10) check("cont_eop", {31'b0, response_eop}, 32'h1);
    end
    csr_rd(1'b1);
    check("cont_busy", csr_readdata, 32'h0);
    csr_rd(1'b0);
    check("cont_ctrl", csr_readdata, 32'h0);

    // Recalibrate: busy for 16 cycles, no beats
    csr_wr(32'hF);
    csr_address = 1'b1;
    csr_read    = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("recal_busy", csr_readdata, {31'b0, (k <= 16)});
      check("recal_valid", {31'b0, response_valid}, 32'h0);
    end
    csr_read = 1'b0;
    csr_rd(1'b0);
    check("recal_ctrl", csr_readdata, 32'hE);

    // Reserved mode with simultaneous read: old value returned, no start
    csr_address   = 1'b0;
    csr_writedata = 32'h5;
    csr_read      = 1'b1;
    csr_write     = 1'b1;
    tick();
    csr_read  = 1'b0;
    csr_write = 1'b0;
    check("rw_pre_value", csr_readdata, 32'hE);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("rsv_valid", {31'b0, response_valid}, 32'h0);
    end
    csr_rd(1'b0);
    check("rsv_ctrl", csr_readdata, 32'h4);
    csr_rd(1'b1);
    check("rsv_busy", csr_readdata, 32'h0);

    // Reset mid-sequence
    csr_wr(32'h1);
    csr_rd(1'b0);
    check("mid_ctrl", csr_readdata, 32'h1);
    check("mid_sample_ch", {27'b0, sample_ch}, 32'd17);
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs("midrst");
    tick();
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("post_rst_valid", {31'b0, response_valid}, 32'h0);
    end
    csr_rd(1'b1);
    check("post_rst_busy", csr_readdata, 32'h0);
    csr_rd(1'b0);
    check("post_rst_ctrl", csr_readdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
